// File: rtl/approx_csel_adder_pipe.sv
`timescale 1ns/1ps
// approx_csel_adder_pipe: 2-stage pipelined segmented carry-select adder with per-segment carry prediction.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   in_valid_i   operand beat valid
//   in_ready_o   block can accept an operand beat
//   a_i, b_i     operands (WIDTH bits)
//   ci_i         carry-in to segment 0
//   sel_i        per-segment carry mode, 0 = rippled carry, 1 = predicted carry (bit 0 ignored)
//   out_valid_o  result valid
//   out_ready_i  consumer accepts result
//   sum_o, co_o  approximate sum and carry-out of the top segment
//   err_o        result differs from the exact {co, sum}
//   err_cnt_o    saturating count of delivered erroneous results
//
// Optional feature macro APPROX_ERR_CNT_EN: when defined, an exact adder runs alongside
// the segmented one to drive err_o and err_cnt_o; otherwise both outputs are tied to 0.
module approx_csel_adder_pipe #(
    parameter int WIDTH     = 16,
    parameter int SEG       = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic                 ci_i,
    input  logic [WIDTH/SEG-1:0] sel_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [WIDTH-1:0]     sum_o,
    output logic                 co_o,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);
    localparam int NSEG = WIDTH / SEG;

    logic             adv1, adv2;
    logic             v1_q, v1_d;
    logic [WIDTH-1:0] s0_q, s0_d, s1_q, s1_d;
    logic [NSEG-1:0]  c0_q, c0_d, c1_q, c1_d;
    logic [NSEG-1:0]  pred_q, pred_d, sel_q, sel_d;
    logic             ci_q, ci_d;
    logic [WIDTH-1:0] sum_res;
    logic             co_res, cy;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             co_q, co_d;

    // Stage 2 may advance when empty or draining; stage 1 when empty or stage 2 advances.
    assign adv2       = !out_valid_q || out_ready_i;
    assign adv1       = !v1_q || adv2;
    assign in_ready_o = adv1;

    // Stage 1: both carry-in candidates per segment plus the MSB generate of the segment below.
    always_comb begin
        v1_d   = adv1 ? in_valid_i : v1_q;
        s0_d   = s0_q;
        s1_d   = s1_q;
        c0_d   = c0_q;
        c1_d   = c1_q;
        pred_d = pred_q;
        sel_d  = sel_q;
        ci_d   = ci_q;
        if (in_valid_i && adv1) begin
            ci_d  = ci_i;
            sel_d = sel_i;
            for (int k = 0; k < NSEG; k++) begin
                {c0_d[k], s0_d[k*SEG +: SEG]} = {1'b0, a_i[k*SEG +: SEG]} + {1'b0, b_i[k*SEG +: SEG]};
                {c1_d[k], s1_d[k*SEG +: SEG]} = {1'b0, a_i[k*SEG +: SEG]} + {1'b0, b_i[k*SEG +: SEG]}
                                                + (SEG+1)'(1);
                // Segment 0 has no predecessor; its carry always comes from ci.
                pred_d[k] = (k != 0) && a_i[k == 0 ? 0 : k*SEG-1] && b_i[k == 0 ? 0 : k*SEG-1];
            end
        end
    end

    // Stage 2: walk the segments, choosing each carry-in from the ripple or the prediction.
    always_comb begin
        sum_res = '0;
        cy      = ci_q;
        for (int k = 0; k < NSEG; k++) begin
            if (k != 0 && sel_q[k])
                cy = pred_q[k];
            sum_res[k*SEG +: SEG] = cy ? s1_q[k*SEG +: SEG] : s0_q[k*SEG +: SEG];
            cy = cy ? c1_q[k] : c0_q[k];
        end
        co_res = cy;
    end

    always_comb begin
        out_valid_d = adv2 ? v1_q : out_valid_q;
        sum_d       = (adv2 && v1_q) ? sum_res : sum_q;
        co_d        = (adv2 && v1_q) ? co_res : co_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v1_q        <= 1'b0;
            s0_q        <= '0;
            s1_q        <= '0;
            c0_q        <= '0;
            c1_q        <= '0;
            pred_q      <= '0;
            sel_q       <= '0;
            ci_q        <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            co_q        <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            c0_q        <= c0_d;
            c1_q        <= c1_d;
            pred_q      <= pred_d;
            sel_q       <= sel_d;
            ci_q        <= ci_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            co_q        <= co_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign sum_o       = sum_q;
    assign co_o        = co_q;

`ifdef APPROX_ERR_CNT_EN
    logic [WIDTH:0]     ex_q, ex_d;
    logic               err_q, err_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        ex_d  = (in_valid_i && adv1) ? {1'b0, a_i} + {1'b0, b_i} + (WIDTH+1)'(ci_i) : ex_q;
        err_d = (adv2 && v1_q) ? (ex_q != {co_res, sum_res}) : err_q;
        // Count only beats the consumer actually takes; stop at all-ones.
        cnt_d = (out_valid_q && out_ready_i && err_q && cnt_q != {ERR_CNT_W{1'b1}}) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_q  <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign err_o     = err_q;
    assign err_cnt_o = cnt_q;
`else
    assign err_o     = 1'b0;
    assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_approx_csel_adder_pipe.sv
`timescale 1ns/1ps
// tb_approx_csel_adder_pipe: randomized and directed checks of approx_csel_adder_pipe against a segment-arithmetic model.
module tb_approx_csel_adder_pipe;
`ifdef APPROX_ERR_CNT_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [15:0] a_i = '0;
    logic [15:0] b_i = '0;
    logic        ci_i = 1'b0;
    logic [3:0]  sel_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [15:0] sum_o;
    logic        co_o;
    logic        err_o;
    logic [3:0]  err_cnt_o;

    int tests = 0;
    int fails = 0;
    logic [17:0] q[$];
    int exp_cnt = 0;

    approx_csel_adder_pipe #(.WIDTH(16), .SEG(4), .ERR_CNT_W(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .a_i(a_i), .b_i(b_i), .ci_i(ci_i), .sel_i(sel_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .sum_o(sum_o), .co_o(co_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns {err, co, sum}: segments added in plain integer arithmetic, carry taken
    // from the previous segment's MSB generate where selected.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci, input logic [3:0] sel);
        int c = ci;
        int s = 0;
        int t;
        int exact = int'(a) + int'(b) + int'(ci);
        for (int k = 0; k < 4; k++) begin
            if (k > 0 && sel[k]) c = a[k*4-1] & b[k*4-1];
            t = ((int'(a) >> (4*k)) & 15) + ((int'(b) >> (4*k)) & 15) + c;
            s = s | ((t & 15) << (4*k));
            c = t >> 4;
        end
        t = (c << 16) | s;
        return {EN && (t != exact), c[0], s[15:0]};
    endfunction

    // Scoreboard: handshakes sampled at the falling edge, they complete at the next rising edge.
    always @(negedge clk_i) begin
        logic [17:0] e;
        if (rst_i) begin
            q.delete();
            exp_cnt = 0;
        end else begin
            check("err_cnt", err_cnt_o, exp_cnt);
            if (out_valid_o && out_ready_i) begin
                if (q.size() == 0) check("sb_extra", 1, 0);
                else begin
                    e = q.pop_front();
                    check("sb_sum", sum_o, e[15:0]);
                    check("sb_co", co_o, e[16]);
                    check("sb_err", err_o, e[17]);
                    if (e[17] && exp_cnt < 15) exp_cnt++;
                end
            end
            if (in_valid_i && in_ready_o) q.push_back(model(a_i, b_i, ci_i, sel_i));
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic [3:0] sel);
        logic acc;
        in_valid_i = 1'b1; a_i = a; b_i = b; ci_i = ci; sel_i = sel;
        for (int n = 0; ; n++) begin
            @(negedge clk_i); acc = in_ready_o;
            @(posedge clk_i); #1;
            if (acc) break;
            if (n > 50) begin check("send_timeout", 0, 1); break; end
        end
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        while (q.size() != 0 && n < 20) begin @(posedge clk_i); #1; n++; end
        check("drain_q", q.size(), 0);
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    task automatic run_random(input int n, input bit rsel);
        logic acc;
        int sent = 0;
        for (int i = 0; i < 5000 && sent < n; i++) begin
            @(negedge clk_i); acc = in_valid_i && in_ready_o;
            @(posedge clk_i); #1;
            if (acc) sent++;
            if (!in_valid_i || acc) begin
                in_valid_i = (sent < n) && ($urandom_range(0, 3) != 0);
                a_i = 16'($urandom); b_i = 16'($urandom); ci_i = 1'($urandom);
                sel_i = rsel ? 4'($urandom) : 4'h0;
            end
            out_ready_i = $urandom_range(0, 3) != 0;
        end
        check("rand_sent", sent, n);
        drain();
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        check("rst_valid", out_valid_o, 0);
        check("rst_sum", sum_o, 0);
        check("rst_co", co_o, 0);
        check("rst_err", err_o, 0);
        check("rst_cnt", err_cnt_o, 0);
        check("rst_rdy", in_ready_o, 1);

        // Carry through every segment, exact mode; result lands two cycles after accept.
        send(16'hFFFF, 16'h0001, 1'b0, 4'b0000);
        check("t1_lat1", out_valid_o, 0);
        @(posedge clk_i); #1;
        check("t1_valid", out_valid_o, 1);
        check("t1_sum", sum_o, 16'h0000);
        check("t1_co", co_o, 1);
        check("t1_err", err_o, 0);

        // Segment 1 predicts carry 0 and loses the real carry.
        send(16'h00FF, 16'h0001, 1'b0, 4'b0010);
        @(posedge clk_i); #1;
        check("t2_sum", sum_o, 16'h00F0);
        check("t2_co", co_o, 0);
        check("t2_err", err_o, EN);
        drain();

        // Backpressure: two beats fill the pipe, third waits, then all drain in order.
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; a_i = 16'd1; b_i = '0; ci_i = 1'b0; sel_i = '0;
        @(negedge clk_i); check("t3_rdy1", in_ready_o, 1);
        @(posedge clk_i); #1 a_i = 16'd2;
        @(negedge clk_i); check("t3_rdy2", in_ready_o, 1);
        @(posedge clk_i); #1 a_i = 16'd3;
        repeat (3) begin
            @(negedge clk_i);
            check("t3_full", in_ready_o, 0);
            check("t3_hold_v", out_valid_o, 1);
            check("t3_hold", sum_o, 1);
        end
        @(posedge clk_i); #1 out_ready_i = 1'b1;
        @(negedge clk_i);
        check("t3_rdy3", in_ready_o, 1);
        check("t3_r1", sum_o, 1);
        @(posedge clk_i); #1 in_valid_i = 1'b0;
        @(negedge clk_i); check("t3_v2", out_valid_o, 1); check("t3_r2", sum_o, 2);
        @(negedge clk_i); check("t3_v3", out_valid_o, 1); check("t3_r3", sum_o, 3);
        @(negedge clk_i); check("t3_done", out_valid_o, 0);
        drain();

        // Reset with both stages full discards everything.
        out_ready_i = 1'b0;
        send(16'h1111, 16'h2222, 1'b0, 4'b0000);
        send(16'h3333, 16'h4444, 1'b1, 4'b0000);
        check("t4_full", out_valid_o, 1);
        rst_i = 1'b1;
        #1 check("t4_rst_v", out_valid_o, 0);
        @(posedge clk_i); #1 rst_i = 1'b0;
        out_ready_i = 1'b1;
        repeat (5) begin @(negedge clk_i); check("t4_stale", out_valid_o, 0); end

        // Counter saturation with repeated erroneous beats; exact beats leave it alone.
        repeat (20) send(16'h00FF, 16'h0001, 1'b0, 4'b0010);
        drain();
        check("t5_sat", err_cnt_o, EN ? 15 : 0);
        repeat (3) send(16'hFFFF, 16'h0001, 1'b0, 4'b0000);
        drain();
        check("t5_hold", err_cnt_o, EN ? 15 : 0);

        // Random exact traffic with random backpressure.
        do_reset();
        run_random(300, 1'b0);
        check("t6_cnt", err_cnt_o, 0);

        // Random approximate traffic.
        run_random(300, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
